// File: rtl/regfile.sv
// regfile: 2-read/1-write register file with hard-wired zero register and async active-low reset.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);
    logic [DATA_W-1:0] mem [NUM_REGS];
    logic              byp1, byp2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign byp1 = we && waddr == raddr1;
    assign byp2 = we && waddr == raddr2;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    // Zero-register check sits above bypass so a write to r0 never leaks through.
    always_comb begin
        rdata1 = (!rst || !re1 || raddr1 == '0) ? '0 : byp1 ? wdata : mem[raddr1];
        rdata2 = (!rst || !re2 || raddr2 == '0) ? '0 : byp2 ? wdata : mem[raddr2];
    end
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed stimulus with a queued-expectation scoreboard for regfile.
module tb_regfile;
    logic        clk = 1'b0;
    logic        rst, we, re1, re2;
    logic [4:0]  waddr, raddr1, raddr2;
    logic [31:0] wdata;
    logic [31:0] rdata1, rdata2;

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t q[$];
    event sample_ev;
    int   n_chk  = 0;
    int   n_fail = 0;

    regfile dut (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .re1   (re1),
        .raddr1(raddr1),
        .rdata1(rdata1),
        .re2   (re2),
        .raddr2(raddr2),
        .rdata2(rdata2)
    );

    always #5 clk = ~clk;

    always begin
        exp_t e;
        @(sample_ev);
        while (q.size() != 0) begin
            e = q.pop_front();
            n_chk++;
            if (rdata1 !== e.e1) begin
                n_fail++;
                $display("FAIL %s rdata1: got %h, expected %h", e.name, rdata1, e.e1);
            end
            n_chk++;
            if (rdata2 !== e.e2) begin
                n_fail++;
                $display("FAIL %s rdata2: got %h, expected %h", e.name, rdata2, e.e2);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        #1;
        e.name = name;
        e.e1   = e1;
        e.e2   = e2;
        q.push_back(e);
        ->sample_ev;
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_byp;
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd3; raddr2 = 5'd31;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hold", 32'h0, 32'h0);

        rst = 1'b1;
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            raddr1 = 5'(i);
            raddr2 = 5'(32 - i);
            check("post_reset_zero", 32'h0, 32'h0);
        end

        re1 = 1'b0; raddr2 = 5'd0;
        wr(5'd5, 32'h1234_5678);
        raddr1 = 5'd5; re1 = 1'b1;
        check("basic_read", 32'h1234_5678, 32'h0);
        re1 = 1'b0;
        check("read_disabled", 32'h0, 32'h0);

        @(negedge clk);
        re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd0; raddr2 = 5'd0;
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        check("r0_before_edge", 32'h0, 32'h0);
        @(posedge clk);
        #1;
        we = 1'b0;
        check("r0_after_edge", 32'h0, 32'h0);

        wr(5'd4, 32'h0000_0001);
        wr(5'd4, 32'h0000_0002);
        raddr1 = 5'd4; raddr2 = 5'd5;
        check("last_write_wins", 32'h0000_0002, 32'h1234_5678);

        wr(5'd7, 32'hAAAA_0000);
        @(negedge clk);
        we = 1'b1; waddr = 5'd7; wdata = 32'h0000_BBBB;
        raddr1 = 5'd7; raddr2 = 5'd7;
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'h0000_BBBB;
`else
        exp_byp = 32'hAAAA_0000;
`endif
        check("same_cycle_bypass", exp_byp, exp_byp);
        @(posedge clk);
        #1;
        we = 1'b0;
        check("bypass_next_cycle", 32'h0000_BBBB, 32'h0000_BBBB);

        wr(5'd9, 32'h5);
        raddr1 = 5'd9; raddr2 = 5'd5;
        check("r9_written", 32'h5, 32'h1234_5678);
        #1;
        rst = 1'b0;
        check("async_reset_drop", 32'h0, 32'h0);
        @(negedge clk);
        we = 1'b1; waddr = 5'd9; wdata = 32'h6;
        @(posedge clk);
        @(negedge clk);
        we = 1'b0;
        rst = 1'b1;
        check("write_lost_in_reset", 32'h0, 32'h0);

        wr(5'd2, 32'h22);
        wr(5'd3, 32'h33);
        raddr1 = 5'd2; raddr2 = 5'd3; re1 = 1'b1; re2 = 1'b0;
        check("indep_re1_only", 32'h22, 32'h0);
        re1 = 1'b0; re2 = 1'b1;
        check("indep_re2_only", 32'h0, 32'h33);
        re1 = 1'b1;
        check("indep_both", 32'h22, 32'h33);

        for (int i = 0; i < 100 && q.size() != 0; i++) #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
